// File: rtl/control_unit_if.sv
// Strobe bundle between the hardwired control unit and the processor datapath.
// The control unit is the master: it reads IR/CON_FF and drives every strobe.
interface control_unit_if;
  logic [31:0] IR;
  logic        CON_FF;

  logic PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
  logic Gra, Grb, Grc, Glink, Rin, Rout, BAout, Cout, CONin;
  logic InPortout, OutPortin;
  logic [4:0] alu_op;
  logic       Run;

  modport master (
    input  IR, CON_FF,
    output PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin,
    output Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
    output Gra, Grb, Grc, Glink, Rin, Rout, BAout, Cout, CONin,
    output InPortout, OutPortin, alu_op, Run
  );

  modport slave (
    output IR, CON_FF,
    input  PCout, PCin, IncPC, MARin, Read, Write, MDRin, MDRout, IRin,
    input  Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
    input  Gra, Grb, Grc, Glink, Rin, Rout, BAout, Cout, CONin,
    input  InPortout, OutPortin, alu_op, Run
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired step-counter sequencer: fetch T0-T2, per-opcode execute T3-T7, HALT.
// Strobes decode from the registered step plus the (stable) opcode held in IR.
module control_unit (
  input  logic             clk,
  input  logic             reset,
  control_unit_if.master   bus
);
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_SHR  = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15, OP_NEG  = 5'd16, OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18, OP_JR   = 5'd19, OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26;

  state_t     state, next;
  logic [4:0] op;
  logic       unused_ir_bits;

  assign op             = bus.IR[31:27];
  assign unused_ir_bits = ^bus.IR[26:0];

  // Final execute step of each instruction class; the step after it is T0.
  function automatic state_t last_step(input logic [4:0] opc);
    case (opc)
      OP_JR, OP_MFHI, OP_MFLO, OP_IN, OP_OUT: return S_T3;
      OP_JAL, OP_NEG, OP_NOT:                 return S_T4;
      OP_BR, OP_MUL, OP_DIV:                  return S_T6;
      OP_LD, OP_ST:                           return S_T7;
      default:                                return S_T5;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      S_RST:  next = S_T0;
      S_T0:   next = S_T1;
      S_T1:   next = S_T2;
      S_T2: begin
        if (op == OP_HALT)                  next = S_HALT;
        else if (op == OP_NOP || op > OP_HALT) next = S_T0;
        else                                next = S_T3;
      end
      S_HALT: next = S_HALT;
      default: next = (state == last_step(op)) ? S_T0 : state_t'(state + 4'd1);
    endcase
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0; bus.MDRin = 1'b0; bus.MDRout = 1'b0;
    bus.IRin = 1'b0; bus.Yin = 1'b0; bus.Zin = 1'b0; bus.Zlowout = 1'b0;
    bus.Zhighout = 1'b0; bus.HIin = 1'b0; bus.HIout = 1'b0; bus.LOin = 1'b0;
    bus.LOout = 1'b0; bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
    bus.Glink = 1'b0; bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
    bus.Cout = 1'b0; bus.CONin = 1'b0; bus.InPortout = 1'b0; bus.OutPortin = 1'b0;
    bus.alu_op = 5'd0;
    bus.Run = (state != S_HALT);

    case (state)
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1;
        bus.Zin = 1'b1; bus.alu_op = OP_ADD;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
      end
      S_T3: begin
        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end
          OP_LD, OP_LDI, OP_ST: begin
            bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
          end
          OP_NEG, OP_NOT: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = op;
          end
          OP_BR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
          OP_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          OP_JAL:  begin bus.PCout = 1'b1; bus.Glink = 1'b1; bus.Rin = 1'b1; end
          OP_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OP_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OP_IN:   begin bus.InPortout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OP_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.OutPortin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op)
          OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR: begin
            bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = op;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = op;
          end
          OP_LD, OP_LDI, OP_ST: begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_ADD;
          end
          OP_MUL, OP_DIV: begin
            bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.alu_op = op;
          end
          OP_NEG, OP_NOT: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OP_BR:          begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
          OP_JAL:         begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op)
          OP_LD, OP_ST:   begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
          OP_MUL, OP_DIV: begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
          OP_BR: begin
            bus.Cout = 1'b1; bus.Zin = 1'b1; bus.alu_op = OP_ADD;
          end
          default: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
        endcase
      end
      S_T6: begin
        case (op)
          OP_LD:          begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
          OP_ST:          begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
          OP_MUL, OP_DIV: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
          // Branch target (PC + C) is taken only when the condition held at T3.
          OP_BR: begin
            bus.Zlowout = bus.CON_FF; bus.PCin = bus.CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op)
          OP_LD:   begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          OP_ST:   bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class step by step
// and compares every strobe, alu_op and Run against hand-written expectations.
module tb_control_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  control_unit_if bus ();
  control_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  localparam logic [27:0] PCOUT   = 28'd1 << 27, PCIN    = 28'd1 << 26;
  localparam logic [27:0] INCPC   = 28'd1 << 25, MARIN   = 28'd1 << 24;
  localparam logic [27:0] READ    = 28'd1 << 23, WRITE   = 28'd1 << 22;
  localparam logic [27:0] MDRIN   = 28'd1 << 21, MDROUT  = 28'd1 << 20;
  localparam logic [27:0] IRIN    = 28'd1 << 19, YIN     = 28'd1 << 18;
  localparam logic [27:0] ZIN     = 28'd1 << 17, ZLOWOUT = 28'd1 << 16;
  localparam logic [27:0] ZHIOUT  = 28'd1 << 15, HIIN    = 28'd1 << 14;
  localparam logic [27:0] HIOUT   = 28'd1 << 13, LOIN    = 28'd1 << 12;
  localparam logic [27:0] LOOUT   = 28'd1 << 11, GRA     = 28'd1 << 10;
  localparam logic [27:0] GRB     = 28'd1 << 9,  GRC     = 28'd1 << 8;
  localparam logic [27:0] GLINK   = 28'd1 << 7,  RIN     = 28'd1 << 6;
  localparam logic [27:0] ROUT    = 28'd1 << 5,  BAOUT   = 28'd1 << 4;
  localparam logic [27:0] COUT    = 28'd1 << 3,  CONIN   = 28'd1 << 2;
  localparam logic [27:0] INPOUT  = 28'd1 << 1,  OUTPIN  = 28'd1 << 0;
  localparam logic [27:0] NONE    = 28'd0;

  logic [27:0] strobes;
  assign strobes = {bus.PCout, bus.PCin, bus.IncPC, bus.MARin, bus.Read, bus.Write,
                    bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Zin, bus.Zlowout,
                    bus.Zhighout, bus.HIin, bus.HIout, bus.LOin, bus.LOout, bus.Gra,
                    bus.Grb, bus.Grc, bus.Glink, bus.Rin, bus.Rout, bus.BAout,
                    bus.Cout, bus.CONin, bus.InPortout, bus.OutPortin};

  task automatic check(input string tag, input logic [27:0] exp_s,
                       input logic [4:0] exp_alu, input logic exp_run);
    checks++;
    assert (strobes === exp_s) else begin
      fails++;
      $error("FAIL %s strobes: got %b expected %b", tag, strobes, exp_s);
    end
    checks++;
    assert (bus.alu_op === exp_alu) else begin
      fails++;
      $error("FAIL %s alu_op: got %0d expected %0d", tag, bus.alu_op, exp_alu);
    end
    checks++;
    assert (bus.Run === exp_run) else begin
      fails++;
      $error("FAIL %s Run: got %b expected %b", tag, bus.Run, exp_run);
    end
  endtask

  // Check the current step, then advance to #1 after the next rising edge.
  task automatic step(input string tag, input logic [27:0] exp_s, input logic [4:0] exp_alu);
    check(tag, exp_s, exp_alu, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic fetch(input string tag);
    step({tag, "/T0"}, PCOUT | MARIN | INCPC | ZIN, 5'd3);
    step({tag, "/T1"}, ZLOWOUT | PCIN | READ | MDRIN, 5'd0);
    step({tag, "/T2"}, MDROUT | IRIN, 5'd0);
  endtask

  initial begin
    reset = 1'b1; bus.IR = 'x; bus.CON_FF = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", NONE, 5'd0, 1'b1);
    reset = 1'b0;
    bus.IR = {5'd3, 4'd1, 4'd2, 4'd3, 15'd0};
    @(posedge clk); #1;

    // add R1,R2,R3
    fetch("add");
    step("add/T3", GRB | ROUT | YIN, 5'd0);
    step("add/T4", GRC | ROUT | ZIN, 5'd3);
    step("add/T5", ZLOWOUT | GRA | RIN, 5'd0);

    // ld R4,0x10(R0)
    bus.IR = {5'd0, 4'd4, 4'd0, 19'h10};
    fetch("ld");
    step("ld/T3", GRB | BAOUT | YIN, 5'd0);
    step("ld/T4", COUT | ZIN, 5'd3);
    step("ld/T5", ZLOWOUT | MARIN, 5'd0);
    step("ld/T6", READ | MDRIN, 5'd0);
    step("ld/T7", MDROUT | GRA | RIN, 5'd0);

    // st R5,0x20(R1)
    bus.IR = {5'd2, 4'd5, 4'd1, 19'h20};
    fetch("st");
    step("st/T3", GRB | BAOUT | YIN, 5'd0);
    step("st/T4", COUT | ZIN, 5'd3);
    step("st/T5", ZLOWOUT | MARIN, 5'd0);
    step("st/T6", GRA | ROUT | MDRIN, 5'd0);
    step("st/T7", WRITE, 5'd0);

    // br taken, then not taken
    bus.IR = {5'd18, 4'd2, 4'd0, 19'h4};
    bus.CON_FF = 1'b1;
    fetch("br1");
    step("br1/T3", GRA | ROUT | CONIN, 5'd0);
    step("br1/T4", PCOUT | YIN, 5'd0);
    step("br1/T5", COUT | ZIN, 5'd3);
    step("br1/T6", ZLOWOUT | PCIN, 5'd0);
    bus.CON_FF = 1'b0;
    fetch("br0");
    step("br0/T3", GRA | ROUT | CONIN, 5'd0);
    step("br0/T4", PCOUT | YIN, 5'd0);
    step("br0/T5", COUT | ZIN, 5'd3);
    step("br0/T6", NONE, 5'd0);

    // mul R3,R4
    bus.IR = {5'd14, 4'd3, 4'd4, 19'd0};
    fetch("mul");
    step("mul/T3", GRA | ROUT | YIN, 5'd0);
    step("mul/T4", GRB | ROUT | ZIN, 5'd14);
    step("mul/T5", ZLOWOUT | LOIN, 5'd0);
    step("mul/T6", ZHIOUT | HIIN, 5'd0);

    // neg R1,R2
    bus.IR = {5'd16, 4'd1, 4'd2, 19'd0};
    fetch("neg");
    step("neg/T3", GRB | ROUT | ZIN, 5'd16);
    step("neg/T4", ZLOWOUT | GRA | RIN, 5'd0);

    // addi R2,R3,-5
    bus.IR = {5'd11, 4'd2, 4'd3, 19'h7fffb};
    fetch("addi");
    step("addi/T3", GRB | ROUT | YIN, 5'd0);
    step("addi/T4", COUT | ZIN, 5'd11);
    step("addi/T5", ZLOWOUT | GRA | RIN, 5'd0);

    // nop and an undefined opcode both fall straight back to T0
    bus.IR = {5'd25, 27'd0};
    fetch("nop");
    bus.IR = {5'd30, 27'd0};
    fetch("op30");

    // one-step execute forms
    bus.IR = {5'd23, 4'd6, 23'd0};
    fetch("mfhi");
    step("mfhi/T3", HIOUT | GRA | RIN, 5'd0);
    bus.IR = {5'd22, 4'd7, 23'd0};
    fetch("out");
    step("out/T3", GRA | ROUT | OUTPIN, 5'd0);
    bus.IR = {5'd21, 4'd8, 23'd0};
    fetch("in");
    step("in/T3", INPOUT | GRA | RIN, 5'd0);
    bus.IR = {5'd19, 4'd9, 23'd0};
    fetch("jr");
    step("jr/T3", GRA | ROUT | PCIN, 5'd0);

    // jal R1 then halt
    bus.IR = {5'd20, 4'd1, 23'd0};
    fetch("jal");
    step("jal/T3", PCOUT | GLINK | RIN, 5'd0);
    step("jal/T4", GRA | ROUT | PCIN, 5'd0);
    bus.IR = {5'd26, 27'd0};
    fetch("halt");
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt/%0d", i), NONE, 5'd0, 1'b0);
      @(posedge clk); #1;
    end

    // reset out of HALT, then abort an ld in T6 with an asynchronous reset
    reset = 1'b1;
    #2 check("halt_reset", NONE, 5'd0, 1'b1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    bus.IR = {5'd0, 4'd4, 4'd0, 19'h10};
    fetch("ld2");
    step("ld2/T3", GRB | BAOUT | YIN, 5'd0);
    step("ld2/T4", COUT | ZIN, 5'd3);
    step("ld2/T5", ZLOWOUT | MARIN, 5'd0);
    check("ld2/T6", READ | MDRIN, 5'd0, 1'b1);
    #2 reset = 1'b1;
    #1 check("ld2/abort", NONE, 5'd0, 1'b1);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("after_abort/T0", PCOUT | MARIN | INCPC | ZIN, 5'd3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
